// File: rtl/vga_pkg.sv
// Shared types and default 640x480@60 timing for the VGA timing generator.
package vga_pkg;

  localparam int unsigned CNT_W   = 10;
  localparam int unsigned CNT_MAX = 1 << CNT_W;

  localparam int unsigned DEF_H_ACTIVE = 640;
  localparam int unsigned DEF_H_FP     = 16;
  localparam int unsigned DEF_H_SYNC   = 96;
  localparam int unsigned DEF_H_BP     = 48;
  localparam int unsigned DEF_V_ACTIVE = 480;
  localparam int unsigned DEF_V_FP     = 10;
  localparam int unsigned DEF_V_SYNC   = 2;
  localparam int unsigned DEF_V_BP     = 33;

  typedef enum logic [1:0] {
    MODE_BARS  = 2'd0,
    MODE_SOLID = 2'd1,
    MODE_CHECK = 2'd2,
    MODE_EXT   = 2'd3
  } mode_e;

endpackage

// File: rtl/vga_pattern_gen.sv
// Next-pixel colour source. With VGA_TEST_PATTERN_EN defined it produces bars,
// solid and checkerboard patterns; otherwise it passes pixel_in through.
module vga_pattern_gen
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE    = DEF_H_ACTIVE,
  parameter int unsigned RGB_W       = 3,
  parameter int unsigned CHECK_SHIFT = 5
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [CNT_W-1:0] hcount_i,
  input  logic [CNT_W-1:0] vcount_i,
  input  logic             de_i,
  input  mode_e            mode_i,
  input  logic [RGB_W-1:0] solid_i,
  input  logic [RGB_W-1:0] pixel_in_i,
  output logic [RGB_W-1:0] rgb_o
);

`ifdef VGA_TEST_PATTERN_EN
  localparam int unsigned BAR_W = H_ACTIVE >> RGB_W;

  if (BAR_W == 0) begin : g_bar_w_check
    $error("vga_pattern_gen: H_ACTIVE too small for 2**RGB_W colour bars");
  end
  if (CHECK_SHIFT >= CNT_W) begin : g_check_shift_check
    $error("vga_pattern_gen: CHECK_SHIFT must be below the counter width");
  end

  localparam logic [CNT_W-1:0] BAR_LAST = CNT_W'(BAR_W - 1);

  logic [CNT_W-1:0] col_q, col_d;
  logic [RGB_W-1:0] bar_q, bar_d;
  logic             check_bit;
  logic             unused_cnt;

  // col_q/bar_q describe the pixel currently on the counters; blanking clears them.
  always_comb begin
    col_d = '0;
    bar_d = '0;
    if (de_i) begin
      if (col_q == BAR_LAST) begin
        col_d = '0;
        bar_d = (bar_q == '1) ? bar_q : bar_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
        bar_d = bar_q;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      col_q <= '0;
      bar_q <= '0;
    end else begin
      col_q <= col_d;
      bar_q <= bar_d;
    end
  end

  assign check_bit  = hcount_i[CHECK_SHIFT] ^ vcount_i[CHECK_SHIFT];
  assign unused_cnt = ^{hcount_i, vcount_i};

  always_comb begin
    rgb_o = '0;
    if (de_i) begin
      case (mode_i)
        MODE_BARS:  rgb_o = bar_q;
        MODE_SOLID: rgb_o = solid_i;
        MODE_CHECK: rgb_o = check_bit ? '1 : '0;
        default:    rgb_o = pixel_in_i;
      endcase
    end
  end
`else
  logic unused_pat;

  assign unused_pat = ^{clk_i, rst_i, hcount_i, vcount_i, mode_i, solid_i};
  assign rgb_o      = de_i ? pixel_in_i : '0;
`endif

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator with registered sync/de/rgb outputs.
// Test patterns are built only when VGA_TEST_PATTERN_EN is defined.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE    = DEF_H_ACTIVE,
  parameter int unsigned H_FP        = DEF_H_FP,
  parameter int unsigned H_SYNC      = DEF_H_SYNC,
  parameter int unsigned H_BP        = DEF_H_BP,
  parameter int unsigned V_ACTIVE    = DEF_V_ACTIVE,
  parameter int unsigned V_FP        = DEF_V_FP,
  parameter int unsigned V_SYNC      = DEF_V_SYNC,
  parameter int unsigned V_BP        = DEF_V_BP,
  parameter logic        HSYNC_POL   = 1'b0,
  parameter logic        VSYNC_POL   = 1'b0,
  parameter int unsigned RGB_W       = 3,
  parameter int unsigned CHECK_SHIFT = 5
) (
  input  logic             clk25MHz,
  input  logic             reset,
  input  logic [1:0]       mode,
  input  logic [RGB_W-1:0] solid_color,
  input  logic [RGB_W-1:0] pixel_in,
  output logic [CNT_W-1:0] pix_x,
  output logic [CNT_W-1:0] pix_y,
  output logic             hsync,
  output logic             vsync,
  output logic             de,
  output logic [RGB_W-1:0] rgb,
  output logic             frame_start
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned EXT_W   = CNT_W + 1;

  if (H_TOTAL > CNT_MAX || V_TOTAL > CNT_MAX) begin : g_total_check
    $error("vga_timing_gen: H_TOTAL/V_TOTAL exceed the 10-bit counter range");
  end

  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
  // Decode windows are one bit wider so a window ending exactly at 1024 still works.
  localparam logic [EXT_W-1:0] H_ACT_X = EXT_W'(H_ACTIVE);
  localparam logic [EXT_W-1:0] V_ACT_X = EXT_W'(V_ACTIVE);
  localparam logic [EXT_W-1:0] HS_BEG  = EXT_W'(H_ACTIVE + H_FP);
  localparam logic [EXT_W-1:0] HS_END  = EXT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [EXT_W-1:0] VS_BEG  = EXT_W'(V_ACTIVE + V_FP);
  localparam logic [EXT_W-1:0] VS_END  = EXT_W'(V_ACTIVE + V_FP + V_SYNC);

  logic [CNT_W-1:0] hcount_q, hcount_d;
  logic [CNT_W-1:0] vcount_q, vcount_d;
  logic [EXT_W-1:0] hx, vy;
  logic             de_c, hs_act, vs_act, first_c, last_c;
  logic             hsync_q, vsync_q, de_q, frame_start_q;
  logic [RGB_W-1:0] rgb_q, rgb_d;
  mode_e            mode_q;
  logic [RGB_W-1:0] solid_q;

  always_comb begin
    hcount_d = hcount_q + 1'b1;
    vcount_d = vcount_q;
    if (hcount_q == H_LAST) begin
      hcount_d = '0;
      vcount_d = (vcount_q == V_LAST) ? '0 : vcount_q + 1'b1;
    end
  end

  assign hx      = {1'b0, hcount_q};
  assign vy      = {1'b0, vcount_q};
  assign de_c    = (hx < H_ACT_X) && (vy < V_ACT_X);
  assign hs_act  = (hx >= HS_BEG) && (hx < HS_END);
  assign vs_act  = (vy >= VS_BEG) && (vy < VS_END);
  assign first_c = (hcount_q == '0) && (vcount_q == '0);
  assign last_c  = (hcount_q == H_LAST) && (vcount_q == V_LAST);

  always_ff @(posedge clk25MHz or posedge reset) begin
    if (reset) begin
      hcount_q      <= '0;
      vcount_q      <= '0;
      hsync_q       <= ~HSYNC_POL;
      vsync_q       <= ~VSYNC_POL;
      de_q          <= 1'b0;
      rgb_q         <= '0;
      frame_start_q <= 1'b0;
    end else begin
      hcount_q      <= hcount_d;
      vcount_q      <= vcount_d;
      hsync_q       <= hs_act ? HSYNC_POL : ~HSYNC_POL;
      vsync_q       <= vs_act ? VSYNC_POL : ~VSYNC_POL;
      de_q          <= de_c;
      rgb_q         <= rgb_d;
      frame_start_q <= first_c;
    end
  end

`ifdef VGA_TEST_PATTERN_EN
  // Latch only on the last pixel of a frame so a pattern change never tears.
  always_ff @(posedge clk25MHz or posedge reset) begin
    if (reset) begin
      mode_q  <= MODE_BARS;
      solid_q <= '0;
    end else if (last_c) begin
      mode_q  <= mode_e'(mode);
      solid_q <= solid_color;
    end
  end
`else
  logic unused_cfg;

  assign mode_q     = MODE_EXT;
  assign solid_q    = '0;
  assign unused_cfg = ^{mode, solid_color, last_c};
`endif

  vga_pattern_gen #(
    .H_ACTIVE    (H_ACTIVE),
    .RGB_W       (RGB_W),
    .CHECK_SHIFT (CHECK_SHIFT)
  ) u_pattern (
    .clk_i      (clk25MHz),
    .rst_i      (reset),
    .hcount_i   (hcount_q),
    .vcount_i   (vcount_q),
    .de_i       (de_c),
    .mode_i     (mode_q),
    .solid_i    (solid_q),
    .pixel_in_i (pixel_in),
    .rgb_o      (rgb_d)
  );

  assign pix_x       = hcount_q;
  assign pix_y       = vcount_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign de          = de_q;
  assign rgb         = rgb_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default-timing table checks plus a randomized
// small-timing run against a frame-position reference model.
module tb_vga_timing_gen;
  import vga_pkg::*;

  logic clk = 1'b0;
  always #20 clk = ~clk;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Default 640x480 instance
  logic       dflt_rst, dflt_hs, dflt_vs, dflt_de, dflt_fs;
  logic [1:0] dflt_mode;
  logic [2:0] dflt_solid, dflt_pixel, dflt_rgb;
  logic [9:0] dflt_pix_x, dflt_pix_y;

  assign dflt_pixel = dflt_pix_x[2:0];

  vga_timing_gen u_dflt (
    .clk25MHz    (clk),
    .reset       (dflt_rst),
    .mode        (dflt_mode),
    .solid_color (dflt_solid),
    .pixel_in    (dflt_pixel),
    .pix_x       (dflt_pix_x),
    .pix_y       (dflt_pix_y),
    .hsync       (dflt_hs),
    .vsync       (dflt_vs),
    .de          (dflt_de),
    .rgb         (dflt_rgb),
    .frame_start (dflt_fs)
  );

  // Small instance: 14-cycle lines, 7-line frames, active-high syncs
  localparam int unsigned S_HA = 8, S_HF = 2, S_HS = 2, S_HB = 2;
  localparam int unsigned S_VA = 4, S_VF = 1, S_VS = 1, S_VB = 1;
  localparam int unsigned S_HT = S_HA + S_HF + S_HS + S_HB;
  localparam int unsigned S_VT = S_VA + S_VF + S_VS + S_VB;
  localparam int unsigned S_FT = S_HT * S_VT;

  logic        sml_rst, sml_hs, sml_vs, sml_de, sml_fs;
  logic [1:0]  sml_mode;
  logic [2:0]  sml_solid, sml_pixel, sml_rgb;
  logic [9:0]  sml_pix_x, sml_pix_y;
  int unsigned salt;

  assign sml_pixel = 3'(sml_pix_x + 3 * sml_pix_y + salt);

  vga_timing_gen #(
    .H_ACTIVE    (S_HA),
    .H_FP        (S_HF),
    .H_SYNC      (S_HS),
    .H_BP        (S_HB),
    .V_ACTIVE    (S_VA),
    .V_FP        (S_VF),
    .V_SYNC      (S_VS),
    .V_BP        (S_VB),
    .HSYNC_POL   (1'b1),
    .VSYNC_POL   (1'b1),
    .RGB_W       (3),
    .CHECK_SHIFT (1)
  ) u_small (
    .clk25MHz    (clk),
    .reset       (sml_rst),
    .mode        (sml_mode),
    .solid_color (sml_solid),
    .pixel_in    (sml_pixel),
    .pix_x       (sml_pix_x),
    .pix_y       (sml_pix_y),
    .hsync       (sml_hs),
    .vsync       (sml_vs),
    .de          (sml_de),
    .rgb         (sml_rgb),
    .frame_start (sml_fs)
  );

  typedef struct {
    int unsigned pos;
    int unsigned bars;
    logic        hs;
    logic        de;
    logic        fs;
  } vec_t;

  vec_t tbl [16];

  // Reference: expected small-instance outputs for frame position pos.
  function automatic logic [2:0] model_rgb(input int unsigned pos, input int unsigned md,
                                           input int unsigned solid, input int unsigned sl);
    int unsigned x, y;
    logic [2:0] pix;
    x   = pos % S_HT;
    y   = pos / S_HT;
    pix = 3'(x + 3 * y + sl);
    if (!(x < S_HA && y < S_VA)) return 3'd0;
`ifdef VGA_TEST_PATTERN_EN
    case (md)
      0:       return 3'((x / (S_HA >> 3)) > 7 ? 7 : (x / (S_HA >> 3)));
      1:       return 3'(solid);
      2:       return (((x >> 1) ^ (y >> 1)) & 1) != 0 ? 3'd7 : 3'd0;
      default: return pix;
    endcase
`else
    return pix;
`endif
  endfunction

  initial begin
    int kpos;
    int unsigned k, pos, nxt, x, y;
    int unsigned mdl_mode, mdl_solid;
    int last_fs, hs_low, hs_first, stray;
    logic [2:0] exp_rgb;

    tbl = '{
      '{0,   0, 1'b1, 1'b1, 1'b1},
      '{79,  0, 1'b1, 1'b1, 1'b0},
      '{80,  1, 1'b1, 1'b1, 1'b0},
      '{81,  1, 1'b1, 1'b1, 1'b0},
      '{159, 1, 1'b1, 1'b1, 1'b0},
      '{160, 2, 1'b1, 1'b1, 1'b0},
      '{559, 6, 1'b1, 1'b1, 1'b0},
      '{560, 7, 1'b1, 1'b1, 1'b0},
      '{639, 7, 1'b1, 1'b1, 1'b0},
      '{640, 0, 1'b1, 1'b0, 1'b0},
      '{655, 0, 1'b1, 1'b0, 1'b0},
      '{656, 0, 1'b0, 1'b0, 1'b0},
      '{751, 0, 1'b0, 1'b0, 1'b0},
      '{752, 0, 1'b1, 1'b0, 1'b0},
      '{799, 0, 1'b1, 1'b0, 1'b0},
      '{800, 0, 1'b1, 1'b1, 1'b0}
    };

    dflt_rst = 1'b1; dflt_mode = 2'd0; dflt_solid = 3'd0;
    sml_rst  = 1'b1; sml_mode  = 2'd0; sml_solid  = 3'd0; salt = 0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_dflt_hsync", dflt_hs, 1);
    check("rst_dflt_vsync", dflt_vs, 1);
    check("rst_dflt_de", dflt_de, 0);
    check("rst_dflt_rgb", dflt_rgb, 0);
    check("rst_dflt_fs", dflt_fs, 0);
    check("rst_dflt_pix_x", dflt_pix_x, 0);
    check("rst_dflt_pix_y", dflt_pix_y, 0);
    check("rst_sml_hsync", sml_hs, 0);
    check("rst_sml_vsync", sml_vs, 0);

    // Phase A: default timing, first two lines
    @(negedge clk);
    dflt_rst = 1'b0;
    kpos = -1;
    for (int i = 0; i < 16; i++) begin
      while (kpos < int'(tbl[i].pos)) begin
        @(posedge clk);
        #1;
        kpos++;
      end
      x = tbl[i].pos % 800;
`ifdef VGA_TEST_PATTERN_EN
      exp_rgb = 3'(tbl[i].bars);
`else
      exp_rgb = tbl[i].de ? 3'(x % 8) : 3'd0;
`endif
      check($sformatf("tbl%0d_rgb", i), dflt_rgb, exp_rgb);
      check($sformatf("tbl%0d_hsync", i), dflt_hs, tbl[i].hs);
      check($sformatf("tbl%0d_de", i), dflt_de, tbl[i].de);
      check($sformatf("tbl%0d_fs", i), dflt_fs, tbl[i].fs);
      check($sformatf("tbl%0d_vsync", i), dflt_vs, 1);
      check($sformatf("tbl%0d_pix_x", i), dflt_pix_x, (tbl[i].pos + 1) % 800);
      check($sformatf("tbl%0d_pix_y", i), dflt_pix_y, (tbl[i].pos + 1) / 800);
    end

    hs_low = 0; hs_first = -1; stray = 0;
    for (int p = 801; p < 1600; p++) begin
      @(posedge clk);
      #1;
      if (dflt_hs == 1'b0) begin
        if (hs_first < 0) hs_first = p;
        hs_low++;
      end
      if (dflt_fs || !dflt_vs) stray++;
    end
    check("dflt_hsync_low_cycles", hs_low, 96);
    check("dflt_hsync_first_pos", hs_first, 800 + 656);
    check("dflt_no_stray_fs_vsync", stray, 0);
    dflt_rst = 1'b1;

    // Phase B: small timing, randomized modes/colours vs the reference model
    @(negedge clk);
    sml_rst = 1'b0;
    k = 0; mdl_mode = 0; mdl_solid = 0; last_fs = -1;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk);
      #1;
      pos = k % S_FT;
      x   = pos % S_HT;
      y   = pos / S_HT;
      nxt = (k + 1) % S_FT;
      check("sml_de", sml_de, (x < S_HA && y < S_VA) ? 1 : 0);
      check("sml_hsync", sml_hs, (x >= S_HA + S_HF && x < S_HA + S_HF + S_HS) ? 1 : 0);
      check("sml_vsync", sml_vs, (y >= S_VA + S_VF && y < S_VA + S_VF + S_VS) ? 1 : 0);
      check("sml_fs", sml_fs, (pos == 0) ? 1 : 0);
      check("sml_rgb", sml_rgb, model_rgb(pos, mdl_mode, mdl_solid, salt));
      check("sml_pix_x", sml_pix_x, nxt % S_HT);
      check("sml_pix_y", sml_pix_y, nxt / S_HT);
      if (sml_fs) begin
        if (last_fs >= 0) check("sml_fs_period", c - last_fs, S_FT);
        last_fs = c;
      end
      if (pos == S_FT - 1) begin
        mdl_mode  = sml_mode;
        mdl_solid = sml_solid;
      end
      k++;

      if ($urandom_range(0, 19) == 0) sml_mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) sml_solid = 3'($urandom);
      salt = $urandom;

      if (c == 1500) begin
        #5 sml_rst = 1'b1;
        #1;
        check("midrst_de", sml_de, 0);
        check("midrst_rgb", sml_rgb, 0);
        check("midrst_hsync", sml_hs, 0);
        check("midrst_vsync", sml_vs, 0);
        check("midrst_fs", sml_fs, 0);
        check("midrst_pix_x", sml_pix_x, 0);
        check("midrst_pix_y", sml_pix_y, 0);
        @(negedge clk);
        sml_rst = 1'b0;
        k = 0; mdl_mode = 0; mdl_solid = 0; last_fs = -1;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
